// File: rtl/inv_pipe_pkg.sv
// Shared constants and helpers for the inv_pipe polarity-correction pipeline.
package inv_pipe_pkg;

  localparam int MAX_STAGES = 8;
  localparam int MAX_WIDTH  = 64;

  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/inv_pipe_stage.sv
// One valid/data slot of the inv_pipe pipeline; accepts new content whenever
// it is empty or its current content leaves in the same cycle.
module inv_pipe_stage
  import inv_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         out_ready_i,
  output logic         in_ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/inv_pipe.sv
// Pipelined masked inverter: Z = A ^ MASK over STAGES handshaked register slots.
// Optional output parity bit Z_PAR is built when INV_PIPE_PARITY_EN is defined.
module inv_pipe
  import inv_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               STAGES     = 2,
  parameter logic [WIDTH-1:0] MASK_RESET = {WIDTH{1'b1}}
) (
  input  logic                            CK,
  input  logic                            RST_N,
  input  logic [WIDTH-1:0]                A,
  input  logic                            A_VALID,
  output logic                            A_READY,
  output logic [WIDTH-1:0]                Z,
  output logic                            Z_VALID,
  input  logic                            Z_READY,
  input  logic                            MASK_LD,
  input  logic [WIDTH-1:0]                MASK_IN,
  output logic [WIDTH-1:0]                MASK,
`ifdef INV_PIPE_PARITY_EN
  output logic                            Z_PAR,
`endif
  output logic [occ_width(STAGES)-1:0]    OCC
);

  localparam int OW = occ_width(STAGES);
`ifdef INV_PIPE_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int SW = WIDTH + PW;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("inv_pipe: WIDTH out of range 1..%0d", MAX_WIDTH);
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("inv_pipe: STAGES out of range 1..%0d", MAX_STAGES);
  end

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [WIDTH-1:0] inv_word;
  logic             accept, emit;

  // vld/dat/rdy index i is the input side of stage i; index STAGES is the output
  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic [SW-1:0]    dat [STAGES+1];

  assign inv_word = A ^ mask_q;

`ifdef INV_PIPE_PARITY_EN
  logic [MAX_WIDTH-1:0] par_ext;
  always_comb begin
    par_ext              = '0;
    par_ext[WIDTH-1:0]   = inv_word;
  end
  assign dat[0] = {even_parity(par_ext), inv_word};
  assign Z_PAR  = dat[STAGES][WIDTH];
`else
  assign dat[0] = inv_word;
`endif

  assign vld[0]      = A_VALID;
  assign rdy[STAGES] = Z_READY;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    inv_pipe_stage #(
      .W(SW)
    ) u_stage (
      .clk_i       (CK),
      .rst_ni      (RST_N),
      .in_valid_i  (vld[i]),
      .in_data_i   (dat[i]),
      .out_ready_i (rdy[i+1]),
      .in_ready_o  (rdy[i]),
      .valid_o     (vld[i+1]),
      .data_o      (dat[i+1])
    );
  end

  // The ready chain runs combinationally from Z_READY back to A_READY
  assign A_READY = RST_N && rdy[0];
  assign Z       = dat[STAGES][WIDTH-1:0];
  assign Z_VALID = vld[STAGES];
  assign accept  = A_VALID && A_READY;
  assign emit    = Z_VALID && Z_READY;

  always_comb begin
    mask_d = MASK_LD ? MASK_IN : mask_q;
    occ_d  = occ_q;
    case ({accept, emit})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      mask_q <= MASK_RESET;
      occ_q  <= '0;
    end else begin
      mask_q <= mask_d;
      occ_q  <= occ_d;
    end
  end

  assign MASK = mask_q;
  assign OCC  = occ_q;

endmodule

// File: tb/tb_inv_pipe.sv
// Directed bench for inv_pipe: a STAGES=2 instance and a STAGES=1 instance.
module tb_inv_pipe;

  logic       CK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] A = '0, MASK_IN = '0;
  logic       A_VALID = 1'b0, Z_READY = 1'b0, MASK_LD = 1'b0;
  logic       A_READY, Z_VALID;
  logic [7:0] Z, MASK;
  logic [1:0] OCC;

  logic [7:0] bA = '0, bMASK_IN = '0;
  logic       bA_VALID = 1'b0, bZ_READY = 1'b0, bMASK_LD = 1'b0;
  logic       bA_READY, bZ_VALID;
  logic [7:0] bZ, bMASK;
  logic [0:0] bOCC;
`ifdef INV_PIPE_PARITY_EN
  logic       Z_PAR, bZ_PAR;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CK = ~CK;

  inv_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .CK(CK), .RST_N(RST_N), .A(A), .A_VALID(A_VALID), .A_READY(A_READY),
    .Z(Z), .Z_VALID(Z_VALID), .Z_READY(Z_READY), .MASK_LD(MASK_LD),
    .MASK_IN(MASK_IN), .MASK(MASK),
`ifdef INV_PIPE_PARITY_EN
    .Z_PAR(Z_PAR),
`endif
    .OCC(OCC));

  inv_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .CK(CK), .RST_N(RST_N), .A(bA), .A_VALID(bA_VALID), .A_READY(bA_READY),
    .Z(bZ), .Z_VALID(bZ_VALID), .Z_READY(bZ_READY), .MASK_LD(bMASK_LD),
    .MASK_IN(bMASK_IN), .MASK(bMASK),
`ifdef INV_PIPE_PARITY_EN
    .Z_PAR(bZ_PAR),
`endif
    .OCC(bOCC));

  task automatic test_reset();
    repeat (2) @(negedge CK);
    total++; if (Z_VALID !== 1'b0) begin bad++; $display("FAIL rst_zvalid got=%b exp=0", Z_VALID); end
    total++; if (Z !== 8'h00) begin bad++; $display("FAIL rst_z got=%h exp=00", Z); end
    total++; if (OCC !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", OCC); end
    total++; if (MASK !== 8'hFF) begin bad++; $display("FAIL rst_mask got=%h exp=ff", MASK); end
    total++; if (A_READY !== 1'b0) begin bad++; $display("FAIL rst_aready_held got=%b exp=0", A_READY); end
    RST_N = 1'b1;
    @(negedge CK);
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL rst_aready_rel got=%b exp=1", A_READY); end
    total++; if (bA_READY !== 1'b1) begin bad++; $display("FAIL rst_aready1_rel got=%b exp=1", bA_READY); end
  endtask

  task automatic test_stream();
    Z_READY = 1'b1; A = 8'h00; A_VALID = 1'b1;
    @(negedge CK);
    total++; if (Z_VALID !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", Z_VALID); end
    A = 8'hA5;
    @(negedge CK);
    A_VALID = 1'b0;
    total++; if (Z_VALID !== 1'b1 || Z !== 8'hFF) begin bad++; $display("FAIL stream_z0 got=%b/%h exp=1/ff", Z_VALID, Z); end
    total++; if (OCC !== 2'd2) begin bad++; $display("FAIL stream_occpk got=%0d exp=2", OCC); end
    @(negedge CK);
    total++; if (Z_VALID !== 1'b1 || Z !== 8'h5A) begin bad++; $display("FAIL stream_z1 got=%b/%h exp=1/5a", Z_VALID, Z); end
    total++; if (OCC !== 2'd1) begin bad++; $display("FAIL stream_occ1 got=%0d exp=1", OCC); end
    @(negedge CK);
    total++; if (Z_VALID !== 1'b0 || OCC !== 2'd0) begin bad++; $display("FAIL stream_drain got=%b/%0d exp=0/0", Z_VALID, OCC); end
  endtask

  task automatic test_mask_inflight();
    A = 8'h0F; A_VALID = 1'b1; MASK_LD = 1'b1; MASK_IN = 8'h00;
    @(negedge CK);
    MASK_LD = 1'b0;
    total++; if (MASK !== 8'h00) begin bad++; $display("FAIL mask_load got=%h exp=00", MASK); end
    @(negedge CK);
    A_VALID = 1'b0;
    total++; if (Z !== 8'hF0) begin bad++; $display("FAIL mask_old got=%h exp=f0", Z); end
    @(negedge CK);
    total++; if (Z_VALID !== 1'b1 || Z !== 8'h0F) begin bad++; $display("FAIL mask_new got=%b/%h exp=1/0f", Z_VALID, Z); end
    MASK_LD = 1'b1; MASK_IN = 8'h3C;
    @(negedge CK);
    total++; if (MASK !== 8'h3C) begin bad++; $display("FAIL mask_b2b0 got=%h exp=3c", MASK); end
    MASK_IN = 8'hFF;
    @(negedge CK);
    MASK_LD = 1'b0;
    total++; if (MASK !== 8'hFF) begin bad++; $display("FAIL mask_b2b1 got=%h exp=ff", MASK); end
  endtask

  task automatic test_backpressure();
    Z_READY = 1'b0; A = 8'h11; A_VALID = 1'b1;
    #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL bp_rdy0 got=%b exp=1", A_READY); end
    @(negedge CK);
    A = 8'h22; #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL bp_rdy1 got=%b exp=1", A_READY); end
    @(negedge CK);
    A = 8'h33;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (A_READY !== 1'b0 || OCC !== 2'd2) begin bad++; $display("FAIL bp_full got=%b/%0d exp=0/2", A_READY, OCC); end
      total++; if (Z_VALID !== 1'b1 || Z !== 8'hEE) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/ee", Z_VALID, Z); end
      @(negedge CK);
    end
    Z_READY = 1'b1; #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", A_READY); end
    @(negedge CK);
    A_VALID = 1'b0;
    total++; if (Z !== 8'hDD || OCC !== 2'd2) begin bad++; $display("FAIL bp_out1 got=%h/%0d exp=dd/2", Z, OCC); end
    @(negedge CK);
    total++; if (Z_VALID !== 1'b1 || Z !== 8'hCC || OCC !== 2'd1) begin bad++; $display("FAIL bp_out2 got=%b/%h/%0d exp=1/cc/1", Z_VALID, Z, OCC); end
    @(negedge CK);
    total++; if (Z_VALID !== 1'b0 || OCC !== 2'd0) begin bad++; $display("FAIL bp_empty got=%b/%0d exp=0/0", Z_VALID, OCC); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [16];
    logic [7:0] exp_q [$];
    logic [7:0] exp;
    int n_out = 0;
    words = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h7E, 8'h3C,
              8'hC3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
    Z_READY = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin A = words[i]; A_VALID = 1'b1; end
      else A_VALID = 1'b0;
      #1;
      if (i < 16) begin
        total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL b2b_rdy[%0d] got=%b exp=1", i, A_READY); end
        total++; if (OCC !== ((i < 2) ? 2'(i) : 2'd2)) begin bad++; $display("FAIL b2b_occ[%0d] got=%0d exp=%0d", i, OCC, (i < 2) ? i : 2); end
        if (A_READY === 1'b1) exp_q.push_back(words[i] ^ 8'hFF);
      end
      if (Z_VALID === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_out++;
        total++; if (Z !== exp) begin bad++; $display("FAIL b2b_z[%0d] got=%h exp=%h", n_out, Z, exp); end
      end
      @(negedge CK);
    end
    total++; if (n_out != 16 || Z_VALID !== 1'b0) begin bad++; $display("FAIL b2b_count got=%0d/%b exp=16/0", n_out, Z_VALID); end
  endtask

  task automatic test_async_reset();
    MASK_LD = 1'b1; MASK_IN = 8'h12;
    @(negedge CK);
    MASK_LD = 1'b0; Z_READY = 1'b0; A = 8'h44; A_VALID = 1'b1;
    repeat (2) @(negedge CK);
    A_VALID = 1'b0;
    total++; if (OCC !== 2'd2 || Z_VALID !== 1'b1) begin bad++; $display("FAIL ar_prefill got=%0d/%b exp=2/1", OCC, Z_VALID); end
    #2 RST_N = 1'b0;
    #1;
    total++; if (Z_VALID !== 1'b0 || Z !== 8'h00) begin bad++; $display("FAIL ar_z got=%b/%h exp=0/00", Z_VALID, Z); end
    total++; if (OCC !== 2'd0 || MASK !== 8'hFF) begin bad++; $display("FAIL ar_state got=%0d/%h exp=0/ff", OCC, MASK); end
    @(negedge CK);
    RST_N = 1'b1; Z_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      total++; if (Z_VALID !== 1'b0) begin bad++; $display("FAIL ar_stale[%0d] got=%b exp=0", i, Z_VALID); end
    end
  endtask

  task automatic test_single_stage();
    bA = 8'h01; bA_VALID = 1'b1; bZ_READY = 1'b0;
    #1;
    total++; if (bA_READY !== 1'b1) begin bad++; $display("FAIL s1_rdy0 got=%b exp=1", bA_READY); end
    @(negedge CK);
    #1;
    total++; if (bA_READY !== 1'b0 || bOCC !== 1'b1) begin bad++; $display("FAIL s1_full got=%b/%0d exp=0/1", bA_READY, bOCC); end
    total++; if (bZ_VALID !== 1'b1 || bZ !== 8'hFE) begin bad++; $display("FAIL s1_z0 got=%b/%h exp=1/fe", bZ_VALID, bZ); end
`ifdef INV_PIPE_PARITY_EN
    total++; if (bZ_PAR !== 1'b1) begin bad++; $display("FAIL s1_par0 got=%b exp=1", bZ_PAR); end
`endif
    bA = 8'h03; bZ_READY = 1'b1; #1;
    total++; if (bA_READY !== 1'b1) begin bad++; $display("FAIL s1_rdy_zr got=%b exp=1", bA_READY); end
    @(negedge CK);
    bA_VALID = 1'b0;
    total++; if (bZ !== 8'hFC || bOCC !== 1'b1) begin bad++; $display("FAIL s1_z1 got=%h/%0d exp=fc/1", bZ, bOCC); end
`ifdef INV_PIPE_PARITY_EN
    total++; if (bZ_PAR !== 1'b0) begin bad++; $display("FAIL s1_par1 got=%b exp=0", bZ_PAR); end
`endif
    @(negedge CK);
    total++; if (bZ_VALID !== 1'b0 || bOCC !== 1'b0) begin bad++; $display("FAIL s1_empty got=%b/%0d exp=0/0", bZ_VALID, bOCC); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_stream();
        test_mask_inflight();
        test_backpressure();
        test_back_to_back();
        test_single_stage();
        test_async_reset();
      end
      begin
        #20000;
        bad++;
        $display("FAIL timeout got=running exp=done");
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_pipe.md
Name: inv_pipe

Overview:
- Parametrised, pipelined successor to the single-bit inverter cell.
- Inverts a WIDTH-bit word under a runtime-programmable per-bit invert mask: Z = A XOR mask.
- The word passes through STAGES registered stages with a valid/ready handshake.
- Used as a polarity-correction stage on registered datapaths between I/O cells and fabric logic, where timing needs the inversion pipelined.

Parameters:
- WIDTH, 8, data word width; legal 1..64.
- STAGES, 2, number of register stages, equal to latency in cycles; legal 1..8.
- MASK_RESET, {WIDTH{1'b1}}, mask value after reset; default inverts all bits, as a plain inverter would.

Ports:
- CK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- A  input  WIDTH  input data word.
- A_VALID  input  1  A holds a valid word.
- A_READY  output  1  block accepts a word this cycle.
- Z  output  WIDTH  output data, A XOR the mask captured with that word.
- Z_VALID  output  1  Z holds a valid word.
- Z_READY  input  1  downstream accepts Z this cycle.
- MASK_LD  input  1  load strobe for the invert mask.
- MASK_IN  input  WIDTH  new mask value.
- MASK  output  WIDTH  currently active mask.
- OCC  output  clog2(STAGES+1)  number of valid words in the pipeline.

Behaviour:
- Reset (RST_N low, asynchronous): all stage valid bits 0, stage data 0, MASK = MASK_RESET, OCC = 0, Z_VALID = 0, Z = 0.
- While reset is held, A_READY = 0.
- On deassertion, state is released on the next CK edge; A_READY = 1 in the first cycle after release.
- Reset mid-operation discards in-flight words with no output.
- Accept rule: a word is accepted when A_VALID && A_READY. On acceptance, stage 0 loads A XOR MASK, using the mask value before any same-cycle MASK_LD.
- Emit rule: a word is delivered when Z_VALID && Z_READY. Z and Z_VALID come from the last stage.
- Stage advance: stage i advances when its successor is empty or its successor advances in the same cycle (bubble collapsing). The last stage advances when Z_READY = 1.
- A_READY = !valid[0] || stage0 advances. This is a combinational path from Z_READY through the valid chain and is accepted by design.
- Latency: with no back-pressure, a word accepted at edge n appears on Z with Z_VALID = 1 after edge n+STAGES-1, i.e. STAGES cycles of register delay.
- Throughput: 1 word/cycle sustained.
- Stall: when Z_VALID && !Z_READY, Z and Z_VALID hold stable until accepted.
- Bubbles fill behind a stalled head. Once all STAGES slots are full, A_READY = 0.
- Mask: MASK_LD = 1 loads MASK_IN into MASK at the edge. The new mask applies only to words accepted in later cycles. Words already in flight keep the mask they captured.
- A simultaneous MASK_LD and accept: the accepted word uses the old mask.
- Back-to-back MASK_LD: the last one wins.
- OCC: +1 on accept, -1 on emit, unchanged when both or neither occur.
- OCC range is 0..STAGES and never wraps; STAGES = OCC when full.
- STAGES = 1: single register; A_READY = !valid || Z_READY.
- A_VALID while A_READY = 0: the word is not taken. The source must hold it, and the block does not check this.

Optional Feature:
- Macro: INV_PIPE_PARITY_EN.
- Defined:
  - Adds output port Z_PAR (1 bit), the even parity (XOR-reduce) of the inverted word.
  - Computed at stage 0 and carried through the pipeline with the data.
  - Reset value 0; held stable with Z under stall.
- Not defined: port absent and no parity registers are built; all other behaviour is identical.

Decomposition:
- Package inv_pipe_pkg holds:
  - function occ_width(STAGES), giving clog2(STAGES+1);
  - localparam MAX_STAGES = 8 and MAX_WIDTH = 64, with elaboration checks against them;
  - function even_parity(word).
- One sub-module, inv_pipe_stage: a single valid/data register with advance logic, instantiated STAGES times through a generate loop. The top level owns the mask register, the OCC counter and the A_READY/Z ports.

Test Plan:
- Reset default: WIDTH = 8, STAGES = 2, stream A = 8'h00, 8'hA5, Z_READY = 1 -> Z = 8'hFF, then 8'h5A, on consecutive cycles; first Z_VALID 2 cycles after first accept; OCC peaks at 2.
- Mask change in flight: accept 8'h0F with mask FF, pulse MASK_LD with MASK_IN = 8'h00 in the same cycle, accept 8'h0F next cycle -> outputs 8'hF0, then 8'h0F.
- Back-pressure: Z_READY = 0 for 5 cycles with A_VALID held -> OCC reaches 2, A_READY = 0, Z stable. On Z_READY = 1, words exit in order with none lost or duplicated.
- Simultaneous accept and emit when full: OCC stays 2 and throughput is 1 word/cycle over 16 random words; scoreboard matches A XOR mask.
- Asynchronous reset mid-stream with OCC = 2 -> Z_VALID = 0, OCC = 0 and MASK = FF immediately, without waiting for CK; no stale word emitted afterwards.
- With INV_PIPE_PARITY_EN, STAGES = 1: A = 8'h01, mask FF -> Z = 8'hFE, Z_PAR = 1; A = 8'h03 -> Z = 8'hFC, Z_PAR = 0.
